// File: rtl/mux_scan_serializer_if.sv
// Load/serial stream signals between mux_scan_serializer and its neighbours.
// master: the upstream/downstream side; slave: the serializer itself.
interface mux_scan_serializer_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       ser_bit;
  logic       ser_valid;
  logic       ser_last;
  logic       ser_ready;

  modport master (
    output load_valid, load_data, ser_ready,
    input  load_ready, ser_bit, ser_valid, ser_last
  );

  modport slave (
    input  load_valid, load_data, ser_ready,
    output load_ready, ser_bit, ser_valid, ser_last
  );
endinterface

// File: rtl/mux_scan_serializer.sv
// Serializes an 8-bit word by stepping the select of an external 8:1 mux.
// The word and select are registered here; the mux output comes back on mux_y
// and is forwarded unchanged as the serial bit.
//
// state | meaning
// IDLE  | waiting for a word (load_ready high once out of reset)
// SCAN  | word held in mux_d, one bit offered per select value
module mux_scan_serializer #(
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_scan_serializer_if.slave  bus,
  output logic [7:0]            mux_d,
  output logic [2:0]            mux_s,
  input  logic                  mux_y,
  output logic                  busy,
  output logic [CNT_W-1:0]      word_cnt
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [2:0] FIRST_SEL = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST_SEL  = (MSB_FIRST != 0) ? 3'd0 : 3'd7;

  state_t           state_q, state_d;
  logic             armed_q;
  logic [7:0]       mux_d_q;
  logic [2:0]       mux_s_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic             load_fire;
  logic             xfer;
  logic             last;

  // State register; armed_q keeps load_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d        = state_q;
    bus.load_ready = 1'b0;
    bus.ser_valid  = 1'b0;
    busy           = 1'b0;
    last           = 1'b0;
    load_fire      = 1'b0;
    xfer           = 1'b0;
    case (state_q)
      IDLE: begin
        bus.load_ready = armed_q;
        if (armed_q && bus.load_valid) begin
          load_fire = 1'b1;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        bus.ser_valid = 1'b1;
        busy          = 1'b1;
        last          = (mux_s_q == LAST_SEL);
        if (bus.ser_ready) begin
          xfer = 1'b1;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word/select/counter datapath; select stays on its final value after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_d_q    <= 8'd0;
      mux_s_q    <= 3'd0;
      word_cnt_q <= '0;
    end else if (load_fire) begin
      mux_d_q <= bus.load_data;
      mux_s_q <= FIRST_SEL;
    end else if (xfer) begin
      if (last) begin
        word_cnt_q <= word_cnt_q + CNT_W'(1);
      end else if (MSB_FIRST != 0) begin
        mux_s_q <= mux_s_q - 3'd1;
      end else begin
        mux_s_q <= mux_s_q + 3'd1;
      end
    end
  end

  assign mux_d        = mux_d_q;
  assign mux_s        = mux_s_q;
  assign word_cnt     = word_cnt_q;
  assign bus.ser_bit  = mux_y;
  assign bus.ser_last = last;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed and random stimulus for two serializer instances (LSB-first with an
// 8-bit counter, MSB-first with a 2-bit counter) sharing clock, reset and
// stimulus. A word-level model (bits remaining per word) gives expected outputs.
module tb_mux_scan_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lv = 1'b0;
  logic [7:0] ld = 8'd0;
  logic       sr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_scan_serializer_if if0 ();
  mux_scan_serializer_if if1 ();

  assign if0.load_valid = lv;
  assign if0.load_data  = ld;
  assign if0.ser_ready  = sr;
  assign if1.load_valid = lv;
  assign if1.load_data  = ld;
  assign if1.ser_ready  = sr;

  logic [7:0] md0, md1;
  logic [2:0] ms0, ms1;
  logic       my0, my1, busy0, busy1;
  logic [7:0] wc0;
  logic [1:0] wc1;

  // External 8:1 muxes
  assign my0 = md0[ms0];
  assign my1 = md1[ms1];

  mux_scan_serializer #(.MSB_FIRST(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .mux_d(md0), .mux_s(ms0),
    .mux_y(my0), .busy(busy0), .word_cnt(wc0));

  mux_scan_serializer #(.MSB_FIRST(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .mux_d(md1), .mux_s(ms1),
    .mux_y(my1), .busy(busy1), .word_cnt(wc1));

  logic       o_lr [2], o_sv [2], o_sl [2], o_sb [2], o_busy [2];
  logic [7:0] o_md [2], o_cnt [2];
  logic [2:0] o_ms [2];

  assign o_lr[0] = if0.load_ready;  assign o_lr[1] = if1.load_ready;
  assign o_sv[0] = if0.ser_valid;   assign o_sv[1] = if1.ser_valid;
  assign o_sl[0] = if0.ser_last;    assign o_sl[1] = if1.ser_last;
  assign o_sb[0] = if0.ser_bit;     assign o_sb[1] = if1.ser_bit;
  assign o_busy[0] = busy0;         assign o_busy[1] = busy1;
  assign o_md[0] = md0;             assign o_md[1] = md1;
  assign o_ms[0] = ms0;             assign o_ms[1] = ms1;
  assign o_cnt[0] = wc0;            assign o_cnt[1] = {6'd0, wc1};

  // Reference model: bits left in the current word, held word, last select, count
  int  m_left [2];
  int  m_word [2];
  int  m_sel_idle [2];
  int  m_cnt [2];
  bit  m_armed;
  logic [7:0] stream [2];

  function automatic int msb_of(input int k);
    return k;
  endfunction

  function automatic int cnt_mod(input int k);
    return (k == 0) ? 256 : 4;
  endfunction

  function automatic int exp_sel(input int k);
    if (m_left[k] == 0) return m_sel_idle[k];
    return (msb_of(k) != 0) ? (m_left[k] - 1) : (8 - m_left[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_word[k] = 0; m_sel_idle[k] = 0; m_cnt[k] = 0;
    end
    m_armed = 1'b0;
  endtask

  task automatic model_edge();
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (m_left[k] == 0) begin
          if (m_armed && lv) begin
            m_word[k] = int'(ld);
            m_left[k] = 8;
          end
        end else if (sr) begin
          if (m_left[k] == 1) begin
            m_cnt[k] = (m_cnt[k] + 1) % cnt_mod(k);
            m_sel_idle[k] = (msb_of(k) != 0) ? 0 : 7;
          end
          m_left[k] = m_left[k] - 1;
        end
      end
      m_armed = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int s;
      s = exp_sel(k);
      chk($sformatf("load_ready%0d", k), 32'(o_lr[k]),   32'(m_armed && m_left[k] == 0));
      chk($sformatf("ser_valid%0d", k),  32'(o_sv[k]),   32'(m_left[k] != 0));
      chk($sformatf("busy%0d", k),       32'(o_busy[k]), 32'(m_left[k] != 0));
      chk($sformatf("ser_last%0d", k),   32'(o_sl[k]),   32'(m_left[k] == 1));
      chk($sformatf("mux_s%0d", k),      32'(o_ms[k]),   32'(s));
      chk($sformatf("mux_d%0d", k),      32'(o_md[k]),   32'(m_word[k]));
      chk($sformatf("ser_bit%0d", k),    32'(o_sb[k]),   32'((m_word[k] >> s) & 1));
      chk($sformatf("word_cnt%0d", k),   32'(o_cnt[k]),  32'(m_cnt[k]));
    end
  endtask

  // One clock: record bits about to transfer, advance model, check after the edge.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      if (rst_n && o_sv[k] && sr) begin
        if (k == 0) stream[0] = {o_sb[0], stream[0][7:1]};
        else        stream[1] = {stream[1][6:0], o_sb[1]};
      end
    end
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [7:0] d);
    lv = 1'b1; ld = d; sr = 1'b1;
    step();
    lv = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    int cnt_start;
    model_reset();
    stream[0] = 8'd0; stream[1] = 8'd0;

    // Reset state
    #2;
    check_all();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("load_ready_after_reset", 32'(o_lr[0]), 32'd1);

    // 0xA5 word
    stream[0] = 8'd0; stream[1] = 8'd0;
    send_word(8'hA5);
    chk("stream0_A5", 32'(stream[0]), 32'hA5);
    chk("stream1_A5", 32'(stream[1]), 32'hA5);
    chk("cnt0_after_A5", 32'(o_cnt[0]), 32'd1);

    // 0x81 word
    stream[0] = 8'd0; stream[1] = 8'd0;
    send_word(8'h81);
    chk("stream1_81", 32'(stream[1]), 32'h81);

    // 0x3C with a 3-cycle stall at bit 2
    stream[0] = 8'd0; stream[1] = 8'd0;
    lv = 1'b1; ld = 8'h3C; sr = 1'b1;
    step();
    lv = 1'b0;
    repeat (2) step();
    sr = 1'b0;
    repeat (3) begin
      step();
      chk("stall_mux_s0", 32'(o_ms[0]), 32'd2);
      chk("stall_ser_bit0", 32'(o_sb[0]), 32'd1);
    end
    sr = 1'b1;
    repeat (6) step();
    chk("stream0_3C", 32'(stream[0]), 32'h3C);
    chk("stream1_3C", 32'(stream[1]), 32'h3C);

    // load_valid held high with changing data: one word per 9 cycles
    cnt_start = int'(o_cnt[0]);
    lv = 1'b1; sr = 1'b1;
    repeat (36) begin
      ld = 8'($urandom);
      step();
    end
    lv = 1'b0;
    chk("held_valid_words", 32'((int'(o_cnt[0]) - cnt_start) & 255), 32'd4);

    // Random traffic
    repeat (300) begin
      lv = 1'($urandom);
      ld = 8'($urandom);
      sr = ($urandom_range(0, 3) != 0);
      step();
    end
    lv = 1'b0; sr = 1'b1;
    repeat (10) step();

    // Reset in the middle of a word
    lv = 1'b1; ld = 8'h5A; sr = 1'b1;
    step();
    lv = 1'b0;
    repeat (4) step();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_rst_cnt0", 32'(o_cnt[0]), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Counter wrap on the 2-bit instance: 1,2,3,0,1
    for (int w = 0; w < 5; w++) begin
      send_word((w == 0) ? 8'hFF : 8'($urandom));
      chk($sformatf("wrap_cnt1_w%0d", w), 32'(o_cnt[1]), 32'((w + 1) % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
